// File: rtl/la_trace_if.sv
// Capture, control and readout signals of the logic-analyzer trace buffer.
// master = analyzer control / host side, slave = trace buffer.
interface la_trace_if #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 5
);
    logic                  la_we;
    logic [DATA_W-1:0]     la_data;
    logic                  sts_ce;
    logic                  clear;
    logic                  rd_req;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_ack;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_err;
    logic [DEPTH_LOG2:0]   sample_cnt;
    logic                  wrapped;
    logic                  frozen;

    modport master (
        output la_we, la_data, sts_ce, clear, rd_req, rd_idx,
        input  rd_ack, rd_data, rd_err, sample_cnt, wrapped, frozen
    );

    modport slave (
        input  la_we, la_data, sts_ce, clear, rd_req, rd_idx,
        output rd_ack, rd_data, rd_err, sample_cnt, wrapped, frozen
    );
endinterface

// File: rtl/la_trace_reader.sv
// Circular sample store frozen by sts_ce, read back by index (0 = oldest) over req/ack.
// Latency: frozen read acks 3 edges after rd_req is sampled, capture-time reject acks after 2.
// Backpressure: none; rd_req is only sampled in CAPTURE/FROZEN, requests in READ/ACK are dropped.
module la_trace_reader #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic       clk,
    input  logic       reset,
    la_trace_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;

    typedef enum logic [1:0] {ST_CAPTURE, ST_FROZEN, ST_READ, ST_ACK} state_t;

    state_t                state_q,   state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,  wr_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q,     cnt_d;
    logic                  wrapped_q, wrapped_d;
    logic [DEPTH_LOG2-1:0] idx_q,     idx_d;
    logic                  err_q,     err_d;
    logic                  ack_frz_q, ack_frz_d;
    logic                  rd_ack_q,  rd_ack_d;
    logic                  rd_err_q,  rd_err_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     ram_q;
    logic                  mem_we;
    logic                  ram_re;
    logic [DEPTH_LOG2-1:0] phys_addr;

    // Once wrapped, the write pointer sits on the oldest entry.
    assign phys_addr = (wrapped_q ? wr_ptr_q : '0) + idx_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        wrapped_d = wrapped_q;
        idx_d     = idx_q;
        err_d     = err_q;
        ack_frz_d = ack_frz_q;
        rd_ack_d  = 1'b0;
        rd_err_d  = 1'b0;
        rd_data_d = rd_data_q;
        mem_we    = 1'b0;
        ram_re    = 1'b0;

        unique case (state_q)
            ST_CAPTURE: begin
                if (bus.la_we) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (wr_ptr_q == PTR_MAX) wrapped_d = 1'b1;
                end
                if (bus.sts_ce) begin
                    state_d = ST_FROZEN;
                end else if (bus.rd_req) begin
                    state_d   = ST_ACK;
                    err_d     = 1'b1;
                    ack_frz_d = 1'b0;
                end
            end
            ST_FROZEN: begin
                if (bus.rd_req) begin
                    state_d   = ST_READ;
                    idx_d     = bus.rd_idx;
                    err_d     = ({1'b0, bus.rd_idx} >= cnt_q);
                    ack_frz_d = 1'b1;
                end
            end
            ST_READ: begin
                ram_re  = !err_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                rd_ack_d  = 1'b1;
                rd_err_d  = err_q;
                rd_data_d = err_q ? '0 : ram_q;
                state_d   = ack_frz_q ? ST_FROZEN : ST_CAPTURE;
            end
            default: state_d = ST_CAPTURE;
        endcase

        // Re-arm overrides everything, including a pending ack and a same-cycle write.
        if (bus.clear) begin
            state_d   = ST_CAPTURE;
            wr_ptr_d  = '0;
            cnt_d     = '0;
            wrapped_d = 1'b0;
            rd_ack_d  = 1'b0;
            rd_err_d  = 1'b0;
            rd_data_d = rd_data_q;
            mem_we    = 1'b0;
            ram_re    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CAPTURE;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            ack_frz_q <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            wrapped_q <= wrapped_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            ack_frz_q <= ack_frz_d;
            rd_ack_q  <= rd_ack_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Sample RAM: no reset, contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= bus.la_data;
        if (ram_re) ram_q <= mem[phys_addr];
    end

    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.wrapped    = wrapped_q;
    assign bus.frozen     = (state_q == ST_FROZEN) || (state_q == ST_READ) ||
                            ((state_q == ST_ACK) && ack_frz_q);
endmodule

// File: tb/tb_la_trace_reader.sv
// Randomized scoreboard bench for la_trace_reader; the model keeps stored samples as an
// oldest-first queue and derives every read result and ack time from it.
module tb_la_trace_reader;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    la_trace_if #(.DATA_W(DW), .DEPTH_LOG2(AW)) bus ();
    la_trace_reader #(.DATA_W(DW), .DEPTH_LOG2(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mq[$];     // stored samples, oldest first
    int            nwr = 0;   // writes since clear/reset
    bit            m_frozen = 0;
    logic [DW-1:0] last_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [DW-1:0] d);
        if (!m_frozen) begin
            mq.push_back(d);
            if (mq.size() > DEPTH) mq.delete(0);
            nwr++;
        end
    endtask

    task automatic write_s(input logic [DW-1:0] d);
        bus.la_we = 1'b1;
        bus.la_data = d;
        tick();
        bus.la_we = 1'b0;
        model_write(d);
    endtask

    task automatic freeze(input bit with_wr, input logic [DW-1:0] d);
        bus.sts_ce = 1'b1;
        bus.la_we = with_wr;
        bus.la_data = d;
        tick();
        bus.sts_ce = 1'b0;
        bus.la_we = 1'b0;
        if (with_wr) model_write(d);
        m_frozen = 1;
    endtask

    task automatic rd(input int idx);
        exp_t e;
        logic [AW-1:0] i5;
        i5 = AW'(idx);
        bus.rd_req = 1'b1;
        bus.rd_idx = i5;
        if (m_frozen) begin
            e.err = (idx >= mq.size());
            e.data = e.err ? '0 : mq[idx];
            e.cyc = cyc + 3;
        end else begin
            e.err = 1'b1;
            e.data = '0;
            e.cyc = cyc + 2;
        end
        exp_q.push_back(e);
        tick();
        bus.rd_req = 1'b0;
        tick();
        if (m_frozen) tick();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        mq.delete();
        nwr = 0;
        m_frozen = 0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cnt"}, 64'(bus.sample_cnt), 64'(mq.size()));
        check({tag, "_wrapped"}, 64'(bus.wrapped), 64'(nwr >= DEPTH));
        check({tag, "_frozen"}, 64'(bus.frozen), 64'(m_frozen));
    endtask

    // Monitor: every ack must match the head of the scoreboard; rd_data must hold otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            last_data = '0;
        end else if (bus.rd_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack actual_data=%0h required=no_ack", bus.rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_data", 64'(bus.rd_data), 64'(e.data));
                check("ack_err", 64'(bus.rd_err), 64'(e.err));
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
            end
            last_data = bus.rd_data;
        end else begin
            check("rd_data_hold", 64'(bus.rd_data), 64'(last_data));
        end
    end

    initial begin
        bus.la_we = 0; bus.la_data = '0; bus.sts_ce = 0; bus.clear = 0;
        bus.rd_req = 0; bus.rd_idx = '0;
        #2;
        check_status("reset");
        check("reset_ack", 64'(bus.rd_ack), 64'(0));
        check("reset_data", 64'(bus.rd_data), 64'(0));
        #10 reset = 1'b1;
        tick();

        // Five samples, frozen, read all back.
        for (int i = 0; i < 5; i++) write_s(32'hA0 + 32'(i));
        freeze(0, '0);
        check_status("t1");
        for (int i = 0; i < 5; i++) rd(i);

        // Wrap: 40 writes into 32 entries.
        do_clear();
        for (int i = 0; i < 40; i++) write_s(32'(i));
        freeze(0, '0);
        check_status("t2");
        rd(0);
        rd(31);
        rd(17);

        // Out-of-range read, then a write attempt while frozen.
        do_clear();
        for (int i = 0; i < 5; i++) write_s(32'hA0 + 32'(i));
        freeze(0, '0);
        rd(7);
        write_s(32'hFF);
        check_status("t3");
        rd(4);

        // Capture-time reject, then write coincident with freeze.
        do_clear();
        for (int i = 0; i < 3; i++) write_s(32'hB0 + 32'(i));
        rd(1);
        freeze(1, 32'h55);
        check_status("t4");
        rd(3);
        rd(4);

        // Clear while a read is in READ: no ack may appear.
        bus.rd_req = 1'b1;
        bus.rd_idx = 5'd0;
        tick();
        bus.rd_req = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        mq.delete(); nwr = 0; m_frozen = 0;
        tick(); tick();
        check_status("t5");
        write_s(32'hC0);
        freeze(0, '0);
        rd(0);

        // Asynchronous reset mid-capture.
        do_clear();
        for (int i = 0; i < 10; i++) write_s(32'hD0 + 32'(i));
        #2 reset = 1'b0;
        #1;
        mq.delete(); nwr = 0; m_frozen = 0;
        check_status("t6");
        check("t6_ack", 64'(bus.rd_ack), 64'(0));
        check("t6_err", 64'(bus.rd_err), 64'(0));
        check("t6_data", 64'(bus.rd_data), 64'(0));
        #3 reset = 1'b1;
        tick();
        write_s(32'hE1);
        write_s(32'hE2);
        freeze(0, '0);
        rd(0);
        rd(1);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            int n;
            do_clear();
            n = $urandom_range(0, 70);
            for (int i = 0; i < n; i++) begin
                write_s($urandom);
                if ($urandom_range(0, 15) == 0) rd($urandom_range(0, 31));
            end
            check_status("rnd_cap");
            freeze($urandom_range(0, 1) == 1, $urandom);
            check_status("rnd_frz");
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 5) == 0) write_s($urandom);
                rd($urandom_range(0, 31));
            end
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
